// File: rtl/matrix_directory_v2_if.sv
// Purpose: bundles the allocate / commit / free / query signals of the matrix directory.
// Latency: no logic of its own; timing comes from the attached directory.
// Backpressure: alloc_busy is the only back-pressure; commit/free/query are always accepted.
interface matrix_directory_v2_if #(
    parameter int MAX_SLOTS = 20,
    parameter int DIM_W     = 5,
    parameter int ADDR_W    = 12,
    parameter int SLOT_W    = $clog2(MAX_SLOTS)
);
    // allocation request / result
    logic                 alloc_req;
    logic [DIM_W-1:0]     alloc_m;
    logic [DIM_W-1:0]     alloc_n;
    logic                 alloc_busy;
    logic                 alloc_done;
    logic                 alloc_ok;
    logic [1:0]           alloc_err;
    logic [SLOT_W-1:0]    alloc_slot;
    logic [ADDR_W-1:0]    alloc_addr;

    // slot lifecycle
    logic                 commit_req;
    logic [SLOT_W-1:0]    commit_slot;
    logic                 free_req;
    logic [SLOT_W-1:0]    free_slot;

    // combinational lookup and occupancy
    logic [SLOT_W-1:0]    query_slot;
    logic                 query_valid;
    logic [DIM_W-1:0]     query_m;
    logic [DIM_W-1:0]     query_n;
    logic [ADDR_W-1:0]    query_addr;
    logic [2*DIM_W-1:0]   query_count;
    logic [SLOT_W:0]      total_count;
    logic [ADDR_W:0]      used_top;

    // requester side
    modport master (
        output alloc_req, alloc_m, alloc_n,
        output commit_req, commit_slot, free_req, free_slot, query_slot,
        input  alloc_busy, alloc_done, alloc_ok, alloc_err, alloc_slot, alloc_addr,
        input  query_valid, query_m, query_n, query_addr, query_count,
        input  total_count, used_top
    );

    // directory side
    modport slave (
        input  alloc_req, alloc_m, alloc_n,
        input  commit_req, commit_slot, free_req, free_slot, query_slot,
        output alloc_busy, alloc_done, alloc_ok, alloc_err, alloc_slot, alloc_addr,
        output query_valid, query_m, query_n, query_addr, query_count,
        output total_count, used_top
    );
endinterface

// File: rtl/matrix_directory_v2.sv
// Purpose: slot directory for matrices in a bump-allocated store (reserve, commit, free, query).
// Latency: alloc_done fires MAX_SLOTS+2 cycles after alloc_req is sampled; commit/free take effect next cycle.
// Backpressure: alloc_req is dropped while alloc_busy=1; commit/free/query are accepted every cycle.
module matrix_directory_v2 #(
    parameter int MAX_SLOTS = 20,
    parameter int DIM_W     = 5,
    parameter int ADDR_W    = 12,
    parameter int CAPACITY  = 4096,
    parameter int SLOT_W    = $clog2(MAX_SLOTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    matrix_directory_v2_if.slave  bus
);
    localparam int MN_W  = 2 * DIM_W;
    localparam int TOP_W = ADDR_W + 1;
    // one spare bit above the wider operand so top + m*n can never wrap
    localparam int SZ_W  = ((TOP_W > MN_W) ? TOP_W : MN_W) + 1;
    localparam logic [SZ_W-1:0]   CAP_SZ   = SZ_W'(CAPACITY);
    localparam logic [SLOT_W-1:0] LAST_IDX = SLOT_W'(MAX_SLOTS - 1);

    typedef enum logic [1:0] {SL_FREE, SL_RSV, SL_VALID} slot_st_e;
    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_CHECK, ST_DONE} fsm_e;

    // slot storage
    slot_st_e           st_q    [MAX_SLOTS];
    logic [DIM_W-1:0]   m_q     [MAX_SLOTS];
    logic [DIM_W-1:0]   n_q     [MAX_SLOTS];
    logic [ADDR_W-1:0]  start_q [MAX_SLOTS];
    logic [TOP_W-1:0]   end_q   [MAX_SLOTS];

    // allocation FSM state
    fsm_e               state_q,    state_d;
    logic [SLOT_W-1:0]  idx_q,      idx_d;
    logic [DIM_W-1:0]   lat_m_q,    lat_m_d;
    logic [DIM_W-1:0]   lat_n_q,    lat_n_d;
    logic               found_q,    found_d;
    logic [SLOT_W-1:0]  free_idx_q, free_idx_d;
    logic [TOP_W-1:0]   top_q,      top_d;

    // result computed in CHECK, published in DONE
    logic               res_ok_q,   res_ok_d;
    logic [1:0]         res_err_q,  res_err_d;
    logic [SLOT_W-1:0]  res_slot_q, res_slot_d;
    logic [ADDR_W-1:0]  res_addr_q, res_addr_d;

    // published result, held between alloc_done pulses
    logic               done_q,     done_d;
    logic               ok_q,       ok_d;
    logic [1:0]         err_q,      err_d;
    logic [SLOT_W-1:0]  slot_q,     slot_d;
    logic [ADDR_W-1:0]  addr_q,     addr_d;

    logic               rsv_en;
    logic [SLOT_W-1:0]  rsv_idx;
    logic [MN_W-1:0]    req_mn;
    logic [SZ_W-1:0]    req_end;
    logic [MAX_SLOTS-1:0] free_hit;
    logic [MAX_SLOTS-1:0] commit_hit;

    logic [DIM_W-1:0]   qry_m;
    logic [DIM_W-1:0]   qry_n;
    logic [ADDR_W-1:0]  qry_addr;
    logic               qry_valid;
    logic [SLOT_W:0]    valid_cnt;
    logic [TOP_W-1:0]   top_all;

    assign req_mn  = MN_W'(lat_m_q) * MN_W'(lat_n_q);
    assign req_end = SZ_W'(top_q) + SZ_W'(req_mn);

    // decode which slots a commit or free request actually changes (out-of-range never matches)
    always_comb begin
        free_hit   = '0;
        commit_hit = '0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            free_hit[i]   = bus.free_req && (32'(bus.free_slot) == i) && (st_q[i] != SL_FREE);
            commit_hit[i] = bus.commit_req && (32'(bus.commit_slot) == i) && (st_q[i] == SL_RSV);
        end
    end

    // slot state updates: free beats reservation beats commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_SLOTS; i++) begin
                st_q[i]    <= SL_FREE;
                m_q[i]     <= '0;
                n_q[i]     <= '0;
                start_q[i] <= '0;
                end_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_SLOTS; i++) begin
                if (free_hit[i]) begin
                    st_q[i] <= SL_FREE;
                end else if (rsv_en && (32'(rsv_idx) == i)) begin
                    st_q[i]    <= SL_RSV;
                    m_q[i]     <= lat_m_q;
                    n_q[i]     <= lat_n_q;
                    start_q[i] <= top_q[ADDR_W-1:0];
                    end_q[i]   <= TOP_W'(req_end);
                end else if (commit_hit[i]) begin
                    st_q[i] <= SL_VALID;
                end
            end
        end
    end

    // allocation FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            lat_m_q    <= '0;
            lat_n_q    <= '0;
            found_q    <= 1'b0;
            free_idx_q <= '1;
            top_q      <= '0;
            res_ok_q   <= 1'b0;
            res_err_q  <= 2'd0;
            res_slot_q <= '1;
            res_addr_q <= '0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 2'd0;
            slot_q     <= '1;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            lat_m_q    <= lat_m_d;
            lat_n_q    <= lat_n_d;
            found_q    <= found_d;
            free_idx_q <= free_idx_d;
            top_q      <= top_d;
            res_ok_q   <= res_ok_d;
            res_err_q  <= res_err_d;
            res_slot_q <= res_slot_d;
            res_addr_q <= res_addr_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            slot_q     <= slot_d;
            addr_q     <= addr_d;
        end
    end

    // allocation FSM next state: latch request, scan one slot per cycle, decide, publish
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        lat_m_d    = lat_m_q;
        lat_n_d    = lat_n_q;
        found_d    = found_q;
        free_idx_d = free_idx_q;
        top_d      = top_q;
        res_ok_d   = res_ok_q;
        res_err_d  = res_err_q;
        res_slot_d = res_slot_q;
        res_addr_d = res_addr_q;
        done_d     = 1'b0;
        ok_d       = ok_q;
        err_d      = err_q;
        slot_d     = slot_q;
        addr_d     = addr_q;
        rsv_en     = 1'b0;
        rsv_idx    = free_idx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.alloc_req) begin
                    lat_m_d    = bus.alloc_m;
                    lat_n_d    = bus.alloc_n;
                    idx_d      = '0;
                    found_d    = 1'b0;
                    free_idx_d = '1;
                    top_d      = '0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // a slot freed after its visit still counts toward top, so the result stays conservative
                if (st_q[idx_q] == SL_FREE) begin
                    if (!found_q) begin
                        found_d    = 1'b1;
                        free_idx_d = idx_q;
                    end
                end else if (end_q[idx_q] > top_q) begin
                    top_d = end_q[idx_q];
                end
                idx_d = idx_q + SLOT_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                res_ok_d   = 1'b0;
                res_slot_d = '1;
                res_addr_d = '0;
                if ((lat_m_q == '0) || (lat_n_q == '0)) begin
                    res_err_d = 2'd1;
                end else if (!found_q) begin
                    res_err_d = 2'd2;
                end else if (req_end > CAP_SZ) begin
                    res_err_d = 2'd3;
                end else begin
                    res_ok_d   = 1'b1;
                    res_err_d  = 2'd0;
                    res_slot_d = free_idx_q;
                    res_addr_d = top_q[ADDR_W-1:0];
                    rsv_en     = 1'b1;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                ok_d    = res_ok_q;
                err_d   = res_err_q;
                slot_d  = res_slot_q;
                addr_d  = res_addr_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // combinational lookup of one slot; fields stay visible after the slot is freed
    always_comb begin
        qry_valid = 1'b0;
        qry_m     = '0;
        qry_n     = '0;
        qry_addr  = '0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            if (32'(bus.query_slot) == i) begin
                qry_valid = (st_q[i] == SL_VALID);
                qry_m     = m_q[i];
                qry_n     = n_q[i];
                qry_addr  = start_q[i];
            end
        end
    end

    // occupancy: number of VALID slots and highest end over live (RESERVED or VALID) slots
    always_comb begin
        valid_cnt = '0;
        top_all   = '0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            if (st_q[i] == SL_VALID) begin
                valid_cnt = valid_cnt + (SLOT_W+1)'(1);
            end
            if ((st_q[i] != SL_FREE) && (end_q[i] > top_all)) begin
                top_all = end_q[i];
            end
        end
    end

    assign bus.alloc_busy  = (state_q != ST_IDLE);
    assign bus.alloc_done  = done_q;
    assign bus.alloc_ok    = ok_q;
    assign bus.alloc_err   = err_q;
    assign bus.alloc_slot  = slot_q;
    assign bus.alloc_addr  = addr_q;
    assign bus.query_valid = qry_valid;
    assign bus.query_m     = qry_m;
    assign bus.query_n     = qry_n;
    assign bus.query_addr  = qry_addr;
    assign bus.query_count = MN_W'(qry_m) * MN_W'(qry_n);
    assign bus.total_count = valid_cnt;
    assign bus.used_top    = top_all;
endmodule

// File: doc/matrix_directory_v2.md
MATRIX_DIRECTORY_V2 -- requirements
Module: matrix_directory_v2

Interface
REQ-001 SHALL have parameters: MAX_SLOTS, default 20, number of directory slots; DIM_W, default 5, row/column width; ADDR_W, default 12, storage address width; CAPACITY, default 4096, total storage elements; SLOT_W, default clog2(MAX_SLOTS), slot index width.
REQ-002 SHALL have ports, one per line, as name, direction, width, meaning:
  clk  in  1  clock
  rst_n  in  1  reset, asynchronous, active-low
  alloc_req  in  1  start allocation; sampled only when alloc_busy=0
  alloc_m, alloc_n  in  DIM_W  requested rows, cols
  alloc_busy  out  1  allocation in progress
  alloc_done  out  1  one-cycle completion pulse
  alloc_ok  out  1  result is valid on alloc_done
  alloc_err  out  2  result code: 0 none, 1 zero dimension, 2 no free slot, 3 no space
  alloc_slot  out  SLOT_W  reserved slot
  alloc_addr  out  ADDR_W  reserved start address
  commit_req  in  1  promote a RESERVED slot to VALID
  commit_slot  in  SLOT_W  slot to commit
  free_req  in  1  release a slot
  free_slot  in  SLOT_W  slot to release
  query_slot  in  SLOT_W  combinational lookup index
  query_valid  out  1  slot is VALID
  query_m, query_n  out  DIM_W  stored dimensions
  query_addr  out  ADDR_W  stored start address
  query_count  out  2*DIM_W  m*n
  total_count  out  SLOT_W+1  number of VALID slots
  used_top  out  ADDR_W+1  highest end address over RESERVED and VALID slots

Function
REQ-003 Each slot SHALL hold the state FREE, RESERVED or VALID, together with m, n, start and end=start+m*n.
REQ-004 The allocation FSM SHALL have the states IDLE, SCAN, CHECK and DONE.
REQ-005 In IDLE, alloc_req=1 SHALL latch alloc_m/alloc_n, set alloc_busy, and go to SCAN.
REQ-006 SCAN SHALL visit one slot per cycle, indices 0..MAX_SLOTS-1, and record the lowest FREE index and the maximum end over non-FREE slots; the state after the last visit SHALL be CHECK.
REQ-007 CHECK SHALL evaluate in priority order: zero m or n gives err 1; no FREE slot gives err 2; top+m*n > CAPACITY gives err 3; otherwise the slot SHALL become RESERVED with the latched m, n, start=top.
REQ-008 DONE SHALL pulse alloc_done for one cycle, clear alloc_busy, hold alloc_slot/alloc_addr/alloc_ok/alloc_err until the next alloc_done, and return to IDLE.
REQ-009 Latency SHALL be fixed: alloc_done is high exactly MAX_SLOTS+2 cycles after the edge that samples alloc_req.
REQ-010 alloc_req while alloc_busy=1 SHALL be ignored (no queueing).
REQ-011 On a failure (alloc_ok=0), alloc_slot SHALL be all-ones, alloc_addr SHALL be 0, and no slot state SHALL change.
REQ-012 commit_req SHALL, one cycle later, change a RESERVED slot to VALID; commit_req on a FREE or VALID slot, or on an index >= MAX_SLOTS, SHALL be ignored.
REQ-013 free_req SHALL set any non-FREE slot to FREE; an out-of-range free_req SHALL be ignored.
REQ-014 When commit_req and free_req target the same slot in the same cycle, free SHALL win.
REQ-015 commit_req and free_req SHALL be accepted in any FSM state.
REQ-016 A slot freed during SCAN after its visit SHALL NOT be used by that allocation, which is conservative and never overlaps.
REQ-017 The slot reserved in CHECK SHALL NOT be affected by a simultaneous free_req to a different slot.
REQ-018 Freeing the top-most region SHALL reclaim its space for the next allocation; interior holes SHALL NOT be reused (bump allocation only).
REQ-019 All size arithmetic SHALL be at least ADDR_W+1 bits wide with no truncation; a request with top+m*n == CAPACITY SHALL succeed.
REQ-020 Query outputs SHALL be combinational from slot storage; a FREE slot SHALL return query_valid=0 with the stored fields unchanged.
REQ-021 total_count and used_top SHALL be combinational from slot states.

Reset
REQ-022 rst_n=0 SHALL, asynchronously, set all slots to FREE with fields zeroed, put the FSM in IDLE, and drive alloc_busy=0, alloc_done=0, alloc_ok=0, alloc_err=0, alloc_slot all-ones and alloc_addr=0.
REQ-023 Reset asserted mid-SCAN SHALL abort the allocation with no alloc_done and no reservation.

Verification
REQ-024 After reset, alloc 4x4 then commit slot 0 -> alloc_done at +22 cycles, slot 0, addr 0, ok=1; after commit, query_valid=1, query_count=16, total_count=1.
REQ-025 Second alloc 3x5 -> slot 1, addr 16; free slot 1 before commit, then alloc 2x2 -> slot 1, addr 16.
REQ-026 Fill CAPACITY exactly with 16x16 requests (16 allocations) -> the 16th succeeds with used_top=4096; the next 1x1 gives ok=0 and err=3.
REQ-027 Twenty successful 1x1 allocations, then one more -> err=2 and alloc_slot all-ones; an alloc 0x3 -> err=1 (zero-dimension check takes priority).
REQ-028 commit_req and free_req on the same slot in one cycle -> slot FREE; alloc_req pulsed while busy -> exactly one alloc_done.
REQ-029 rst_n low at SCAN cycle 10 -> no alloc_done, all slots FREE, total_count=0.
